// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART parity encodings, FSM state type and frame helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
// uart_baud_tick : bit-period counter, tick marks the last clk of each period
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIVISOR = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int                 C_CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(DIVISOR - 1);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("uart_baud_tick: DIVISOR must be at least 2");
        end
    endgenerate

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == C_LAST);
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_framer.sv
// ============================================================================
// uart_tx_framer : valid/ready UART transmitter, start/data/parity/stop framing
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int PARITY    = 0,
    parameter int CLK_RATE  = 12000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int         C_DIVISOR   = CLK_RATE / BAUD_RATE;
    localparam logic [3:0] C_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] C_LAST_STOP = 4'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY < PARITY_NONE || PARITY > PARITY_ODD || C_DIVISOR < 2) begin : g_bad_params
            $error("uart_tx_framer: parameter out of range");
        end
    endgenerate

    uart_state_e          state_q,   state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,   shreg_d;
    logic                 parity_q,  parity_d;
    logic                 tx_q,      tx_d;
    logic                 baud_tick;
    logic                 handshake;

    uart_baud_tick #(
        .DIVISOR (C_DIVISOR)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (handshake),
        .tick  (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        tx_ready  = (state_q == ST_IDLE) ||
                    (state_q == ST_STOP && baud_tick && bit_cnt_q == C_LAST_STOP);
        handshake = tx_valid && tx_ready;

        case (state_q)
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == C_LAST_DATA) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shreg_d   = shreg_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (bit_cnt_q == C_LAST_STOP) begin
                        state_d   = ST_IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase

        // A handshake in the final stop cycle overrides the return to IDLE.
        if (handshake) begin
            state_d   = ST_START;
            bit_cnt_d = '0;
            shreg_d   = tx_data;
            parity_d  = (PARITY == PARITY_ODD) ? ~(^tx_data) : (^tx_data);
        end

        // tx is registered, so it is derived from the state being entered.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// ============================================================================
// tb_uart_tx_framer : four framer configurations checked against a bit-list model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_framer;

    localparam int DIV = 4;
    localparam int NI  = 4;

    typedef bit bits_q_t[$];

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    d0 = '0, d1 = '0, d2 = '0;
    logic [6:0]    d3 = '0;
    logic [NI-1:0] vld = '0;
    logic [NI-1:0] rdy, txl, bsy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .CLK_RATE(40), .BAUD_RATE(10)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(vld[0]),
        .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]));
    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1), .CLK_RATE(40), .BAUD_RATE(10)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(vld[1]),
        .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]));
    uart_tx_framer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .CLK_RATE(40), .BAUD_RATE(10)) u_8o1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(vld[2]),
        .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]));
    uart_tx_framer #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(0), .CLK_RATE(40), .BAUD_RATE(10)) u_7n2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_valid(vld[3]),
        .tx_ready(rdy[3]), .tx(txl[3]), .busy(bsy[3]));

    function automatic int cfg_db(int k);  return (k == 3) ? 7 : 8;              endfunction
    function automatic int cfg_sb(int k);  return (k == 3) ? 2 : 1;              endfunction
    function automatic int cfg_par(int k); return (k == 1) ? 1 : (k == 2) ? 2 : 0; endfunction

    // Line levels of one frame, one entry per bit period.
    function automatic bits_q_t model_frame(int k, int w);
        bits_q_t q;
        int      ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < cfg_db(k); i++) begin
            q.push_back(bit'((w >> i) & 1));
            ones += (w >> i) & 1;
        end
        if (cfg_par(k) == 1) q.push_back(bit'(ones % 2));
        if (cfg_par(k) == 2) q.push_back(bit'((ones + 1) % 2));
        for (int i = 0; i < cfg_sb(k); i++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic set_data(int k, int w);
        case (k)
            0:       d0 = 8'(w);
            1:       d1 = 8'(w);
            2:       d2 = 8'(w);
            default: d3 = 7'(w);
        endcase
    endtask

    task automatic send_frame(string name, int k, int w, bit change, int alt);
        bits_q_t q;
        int      n;
        q = model_frame(k, w);
        n = q.size() * DIV;
        @(negedge clk);
        checks++;
        if (rdy[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_ready k=%0d: got %b want 1", name, k, rdy[k]);
        end
        set_data(k, w);
        vld[k] = 1'b1;
        @(posedge clk);
        #1 vld[k] = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            checks++;
            if (txl[k] !== q[c / DIV]) begin
                errors++;
                $display("FAIL %s tx k=%0d cycle=%0d: got %b want %b", name, k, c, txl[k], q[c / DIV]);
            end
            checks++;
            if (rdy[k] !== (c == n - 1)) begin
                errors++;
                $display("FAIL %s ready k=%0d cycle=%0d: got %b want %b", name, k, c, rdy[k], (c == n - 1));
            end
            checks++;
            if (bsy[k] !== 1'b1) begin
                errors++;
                $display("FAIL %s busy k=%0d cycle=%0d: got %b want 1", name, k, c, bsy[k]);
            end
            if (change && c == 0) set_data(k, alt);
        end
        @(negedge clk);
        checks++;
        if (txl[k] !== 1'b1 || bsy[k] !== 1'b0 || rdy[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s after_frame k=%0d: got tx=%b busy=%b ready=%b want 1 0 1",
                     name, k, txl[k], bsy[k], rdy[k]);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (txl !== '1 || bsy !== '0) begin
            errors++;
            $display("FAIL reset_values: got tx=%b busy=%b want 1111 0000", txl, bsy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy !== '1 || txl !== '1 || bsy !== '0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b tx=%b busy=%b want 1111 1111 0000", rdy, txl, bsy);
        end
    endtask

    task automatic test_8n1();
        send_frame("8n1_a5", 0, 8'hA5, 1'b0, 0);
    endtask

    task automatic test_parity();
        send_frame("even_07", 1, 8'h07, 1'b0, 0);
        send_frame("odd_07", 2, 8'h07, 1'b0, 0);
        send_frame("even_rnd", 1, int'($urandom_range(0, 255)), 1'b0, 0);
        send_frame("odd_rnd", 2, int'($urandom_range(0, 255)), 1'b0, 0);
    endtask

    task automatic test_7n2();
        send_frame("7n2_55", 3, 8'h55, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        bits_q_t q;
        bits_q_t q2;
        q  = model_frame(0, 8'h00);
        q2 = model_frame(0, 8'hFF);
        foreach (q2[i]) q.push_back(q2[i]);
        @(negedge clk);
        d0     = 8'h00;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 d0 = 8'hFF;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            checks++;
            if (txl[0] !== q[c / DIV]) begin
                errors++;
                $display("FAIL b2b tx cycle=%0d: got %b want %b", c, txl[0], q[c / DIV]);
            end
            checks++;
            if (bsy[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b busy cycle=%0d: got %b want 1", c, bsy[0]);
            end
            checks++;
            if (rdy[0] !== (c == 39 || c == 79)) begin
                errors++;
                $display("FAIL b2b ready cycle=%0d: got %b want %b", c, rdy[0], (c == 39 || c == 79));
            end
            if (c >= 40) vld[0] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (bsy[0] !== 1'b0 || txl[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b end: got busy=%b tx=%b want 0 1", bsy[0], txl[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        d0     = 8'h00;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        // Cycle 17 lies inside data bit 3 (bit period 4).
        repeat (18) @(negedge clk);
        checks++;
        if (txl[0] !== 1'b0 || bsy[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got tx=%b busy=%b want 0 1", txl[0], bsy[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: got tx=%b busy=%b want 1 0", txl[0], bsy[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdy[0] !== 1'b1 || txl[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_release: got ready=%b tx=%b want 1 1", rdy[0], txl[0]);
        end
        send_frame("after_abort_3c", 0, 8'h3C, 1'b0, 0);
    endtask

    task automatic test_data_change();
        send_frame("hold_81", 0, 8'h81, 1'b1, 8'h7E);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int k;
            int w;
            k = int'($urandom_range(0, NI - 1));
            w = int'($urandom_range(0, 255));
            if (k == 3) w = w & 8'h7F;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_frame("random", k, w, 1'b0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_reset_mid_frame();
        test_data_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
